fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID/EX register. It owns the PC and issues requests to instruction memory over a req/ready handshake. It registers {PC, instruction, valid} for decode, holding on hazard stall and flushing on a branch redirect from EX. All state updates on posedge clk.

---
 rtl/mips_pkg.sv | 14 +
 rtl/fetch_stage_if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package mips_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset/flush insert a bubble, load captures a new
// instruction, otherwise contents hold.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC/address registers, a one-word skid buffer for data
// returned under stall, and a stale-response filter after redirects.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  hold_q, hold_d;
  logic         load, flush;
  logic [31:0]  load_pc, load_instr;
  logic [31:0]  target;
  logic [31:0]  pc_next;

  assign target  = redirect_pc & ~32'h3;
  assign pc_next = pc_q + PC_INC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    load       = 1'b0;
    flush      = 1'b0;
    load_pc    = pc_q;
    load_instr = imem_rdata;
    case (state_q)
      REQ: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = target;
          if (imem_ready) addr_d = target;
          else            state_d = DROP;
        end else if (imem_ready && !stall) begin
          load   = 1'b1;
          pc_d   = pc_next;
          addr_d = pc_next;
        end else if (imem_ready) begin
          hold_d  = imem_rdata;
          state_d = HOLD;
        end else if (!stall) begin
          flush = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = target;
          addr_d  = target;
          state_d = REQ;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = hold_q;
          pc_d       = pc_next;
          addr_d     = pc_next;
          state_d    = REQ;
        end
      end
      DROP: begin
        // The outstanding response belongs to a squashed path; never load it.
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = target;
          if (imem_ready) begin
            addr_d  = target;
            state_d = REQ;
          end
        end else begin
          if (imem_ready) begin
            addr_d  = pc_q;
            state_d = REQ;
          end
          if (!stall) flush = 1'b1;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign imem_req  = (state_q != HOLD);
  assign imem_addr = addr_q;

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .flush_i (flush),
    .pc_i    (load_pc),
    .instr_i (load_instr),
    .pc_o    (PC_out),
    .instr_o (instruction_out),
    .valid_o (valid_out)
  );

endmodule
